// File: rtl/ex_mem_wb_pipeline.sv
// ============================================================================
// Module      : ex_mem_wb_pipeline
// Description : EX/MEM and MEM/WB pipeline registers with data-memory handshake
//               and forwarding outputs. Optional macro RETIRE_COUNT_EN adds a
//               64-bit retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_wb_pipeline #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic            ex_memtoreg,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            ex_stall,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic            EX_MEM_RegWrite,
  output logic [4:0]      EX_MEM_RegisterRD,
  output logic [XLEN-1:0] ex_mem_fwd_data,
  output logic            MEM_WB_RegWrite,
  output logic [4:0]      MEM_WB_RegisterRD,
  output logic [XLEN-1:0] wb_data
`ifdef RETIRE_COUNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_OCC_ALU = 2'd1;
  localparam logic [1:0] c_OCC_MEM = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_nextState;
  logic            r_emRegWrite;
  logic            r_emMemRead;
  logic            r_emMemWrite;
  logic            r_emMemToReg;
  logic [4:0]      r_emRd;
  logic [XLEN-1:0] r_emAlu;
  logic [XLEN-1:0] r_emSData;
  logic            r_wbValid;
  logic            r_wbRegWrite;
  logic [4:0]      r_wbRd;
  logic [XLEN-1:0] r_wbVal;
  logic            w_emValid;
  logic            w_hold;
  logic            w_wbLoad;

  // State register: the EX/MEM valid bit is encoded in the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = c_IDLE;
    end else if (!w_hold) begin
      if (!ex_valid)                        w_nextState = c_IDLE;
      else if (ex_memread || ex_memwrite)   w_nextState = c_OCC_MEM;
      else                                  w_nextState = c_OCC_ALU;
    end
  end

  always_comb begin
    w_emValid       = 1'b0;
    w_hold          = 1'b0;
    case (r_state)
      c_OCC_ALU: w_emValid = 1'b1;
      c_OCC_MEM: begin
        w_emValid = 1'b1;
        w_hold    = ~mem_ready;
      end
      default:   w_emValid = 1'b0;
    endcase
    ex_stall        = w_hold;
    mem_read        = w_emValid & r_emMemRead;
    mem_write       = w_emValid & r_emMemWrite;
    EX_MEM_RegWrite = w_emValid & r_emRegWrite & (r_emRd != 5'd0);
    MEM_WB_RegWrite = r_wbValid & r_wbRegWrite & (r_wbRd != 5'd0);
    w_wbLoad        = w_emValid & ~w_hold & ~flush;
  end

  // EX/MEM payload; contents are only meaningful while the state is occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_emRegWrite <= 1'b0;
      r_emMemRead  <= 1'b0;
      r_emMemWrite <= 1'b0;
      r_emMemToReg <= 1'b0;
      r_emRd       <= '0;
      r_emAlu      <= '0;
      r_emSData    <= '0;
    end else if (!flush && !w_hold) begin
      r_emRegWrite <= ex_regwrite;
      r_emMemRead  <= ex_memread;
      r_emMemWrite <= ex_memwrite;
      r_emMemToReg <= ex_memtoreg;
      r_emRd       <= ex_rd;
      r_emAlu      <= ex_alu_result;
      r_emSData    <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbValid    <= 1'b0;
      r_wbRegWrite <= 1'b0;
      r_wbRd       <= '0;
      r_wbVal      <= '0;
    end else begin
      r_wbValid    <= w_wbLoad;
      r_wbRegWrite <= w_wbLoad & r_emRegWrite;
      if (w_wbLoad) begin
        r_wbRd  <= r_emRd;
        r_wbVal <= r_emMemToReg ? mem_rdata : r_emAlu;
      end
    end
  end

  assign mem_addr          = r_emAlu;
  assign mem_wdata         = r_emSData;
  assign EX_MEM_RegisterRD = r_emRd;
  assign ex_mem_fwd_data   = r_emAlu;
  assign MEM_WB_RegisterRD = r_wbRd;
  assign wb_data           = r_wbVal;

`ifdef RETIRE_COUNT_EN
  logic [63:0] r_retireCount;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_retireCount <= '0;
    else if (w_wbLoad) r_retireCount <= r_retireCount + 64'd1;
  end

  assign retire_count = r_retireCount;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_wb_pipeline.sv
// ============================================================================
// Module      : tb_ex_mem_wb_pipeline
// Description : Directed scoreboard bench for ex_mem_wb_pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_wb_pipeline;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset_n;
  logic            flush;
  logic            ex_valid;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_memtoreg;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] ex_store_data;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            ex_stall;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_read;
  logic            mem_write;
  logic            EX_MEM_RegWrite;
  logic [4:0]      EX_MEM_RegisterRD;
  logic [XLEN-1:0] ex_mem_fwd_data;
  logic            MEM_WB_RegWrite;
  logic [4:0]      MEM_WB_RegisterRD;
  logic [XLEN-1:0] wb_data;
`ifdef RETIRE_COUNT_EN
  logic [63:0]     retire_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [4:0]      expRd[$];
  logic [XLEN-1:0] expVal[$];

  ex_mem_wb_pipeline #(.XLEN(XLEN)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .ex_valid          (ex_valid),
    .ex_regwrite       (ex_regwrite),
    .ex_memread        (ex_memread),
    .ex_memwrite       (ex_memwrite),
    .ex_memtoreg       (ex_memtoreg),
    .ex_rd             (ex_rd),
    .ex_alu_result     (ex_alu_result),
    .ex_store_data     (ex_store_data),
    .mem_ready         (mem_ready),
    .mem_rdata         (mem_rdata),
    .ex_stall          (ex_stall),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .EX_MEM_RegWrite   (EX_MEM_RegWrite),
    .EX_MEM_RegisterRD (EX_MEM_RegisterRD),
    .ex_mem_fwd_data   (ex_mem_fwd_data),
    .MEM_WB_RegWrite   (MEM_WB_RegWrite),
    .MEM_WB_RegisterRD (MEM_WB_RegisterRD),
    .wb_data           (wb_data)
`ifdef RETIRE_COUNT_EN
    ,
    .retire_count      (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkAllZero(input string name);
    logic w_any;
    w_any = ex_stall | (|mem_addr) | (|mem_wdata) | mem_read | mem_write |
            EX_MEM_RegWrite | (|EX_MEM_RegisterRD) | (|ex_mem_fwd_data) |
            MEM_WB_RegWrite | (|MEM_WB_RegisterRD) | (|wb_data);
    chk(name, {63'd0, w_any}, 64'd0);
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic mtr, input logic [4:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] sd);
    ex_valid      = v;
    ex_regwrite   = rw;
    ex_memread    = mr;
    ex_memwrite   = mw;
    ex_memtoreg   = mtr;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
  endtask

  task automatic expectWb(input logic [4:0] rd, input logic [XLEN-1:0] val);
    expRd.push_back(rd);
    expVal.push_back(val);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-back monitor: every visible register-file write must match the scoreboard.
  always @(negedge clk) begin
    if (reset_n && MEM_WB_RegWrite) begin
      if (expRd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write", MEM_WB_RegisterRD, wb_data);
      end else begin
        chk("wb_rd", {59'd0, MEM_WB_RegisterRD}, {59'd0, expRd.pop_front()});
        chk("wb_data", {32'd0, wb_data}, {32'd0, expVal.pop_front()});
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = '0;
    idle();
    #3;
    chkAllZero("reset_outputs");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) step();
    chkAllZero("idle_outputs");
    chk("idle_stall", {63'd0, ex_stall}, 64'd0);

    // ALU op rd=5
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
    expectWb(5'd5, 32'h1234);
    step();
    idle();
    chk("alu_em_rw", {63'd0, EX_MEM_RegWrite}, 64'd1);
    chk("alu_em_rd", {59'd0, EX_MEM_RegisterRD}, 64'd5);
    chk("alu_fwd", {32'd0, ex_mem_fwd_data}, 64'h1234);
    step();
    chk("alu_wb_rw", {63'd0, MEM_WB_RegWrite}, 64'd1);

    // Load rd=7 from 0x40, two wait cycles
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h40, 32'h0);
    mem_ready = 1'b0;
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      chk("ld_stall", {63'd0, ex_stall}, 64'd1);
      chk("ld_mem_read", {63'd0, mem_read}, 64'd1);
      chk("ld_mem_addr", {32'd0, mem_addr}, 64'h40);
      chk("ld_wb_bubble", {63'd0, MEM_WB_RegWrite}, 64'd0);
      if (i == 0) step();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    expectWb(5'd7, 32'hDEADBEEF);
    #1;
    chk("ld_stall_release", {63'd0, ex_stall}, 64'd0);
    step();
    mem_rdata = 32'h0BAD0BAD;
    chk("ld_read_drop", {63'd0, mem_read}, 64'd0);
    chk("ld_wb_rw", {63'd0, MEM_WB_RegWrite}, 64'd1);

    // Store killed by flush on its second hold cycle, with a new instruction dropped
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'h55);
    mem_ready = 1'b0;
    step();
    idle();
    chk("st_mem_write", {63'd0, mem_write}, 64'd1);
    chk("st_wdata", {32'd0, mem_wdata}, 64'h55);
    chk("st_stall", {63'd0, ex_stall}, 64'd1);
    step();
    chk("st_stall2", {63'd0, ex_stall}, 64'd1);
`ifdef RETIRE_COUNT_EN
    chk("retire_before_flush", retire_count, 64'd2);
`endif
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h999, 32'h0);
    step();
    flush = 1'b0;
    idle();
    chk("fl_mem_write", {63'd0, mem_write}, 64'd0);
    chk("fl_stall", {63'd0, ex_stall}, 64'd0);
    chk("fl_dropped", {63'd0, EX_MEM_RegWrite}, 64'd0);
    mem_ready = 1'b1;
    step();
    step();
`ifdef RETIRE_COUNT_EN
    chk("retire_after_flush", retire_count, 64'd2);
`endif

    // ALU op to x0 never becomes visible
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h99, 32'h0);
    step();
    idle();
    chk("x0_em_rw", {63'd0, EX_MEM_RegWrite}, 64'd0);
    step();
    chk("x0_wb_rw", {63'd0, MEM_WB_RegWrite}, 64'd0);

    // Back-to-back ALU ops
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h11, 32'h0);
    expectWb(5'd3, 32'h11);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h22, 32'h0);
    expectWb(5'd4, 32'h22);
    step();
    idle();
    chk("b2b_em_rd", {59'd0, EX_MEM_RegisterRD}, 64'd4);
    step();
    step();

    // Asynchronous reset with both stages occupied
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'hA, 32'h0);
    expectWb(5'd10, 32'hA);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'hB, 32'h0);
    step();
    idle();
    chk("rst_pre_em", {63'd0, EX_MEM_RegWrite}, 64'd1);
    chk("rst_pre_wb", {63'd0, MEM_WB_RegWrite}, 64'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chkAllZero("async_reset_outputs");
`ifdef RETIRE_COUNT_EN
    chk("retire_reset", retire_count, 64'd0);
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    step();
    chk("sb_empty", {32'd0, expRd.size()}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mem_wb_pipeline.md
Name: ex_mem_wb_pipeline

Overview:
- Two-stage back-end pipeline register bank: EX/MEM and MEM/WB.
- Captures EX-stage results and drives the data-memory interface.
- Holds EX/MEM while memory is not ready; produces the final write-back value.
- Sources the EX_MEM_RegWrite/RD and MEM_WB_RegWrite/RD signals and forwarding data consumed by the forwarding unit and the ALU operand muxes.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction currently in EX/MEM (branch/trap redirect)
- ex_valid  in  1  EX stage presents a real instruction
- ex_regwrite  in  1  instruction writes rd
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_memtoreg  in  1  write-back selects load data
- ex_rd  in  5  destination register
- ex_alu_result  in  XLEN  ALU result / memory address
- ex_store_data  in  XLEN  forwarded rs2 value for stores
- mem_ready  in  1  data memory completes the access this cycle
- mem_rdata  in  XLEN  load data, valid when mem_ready=1
- ex_stall  out  1  back-pressure to EX and earlier stages
- mem_addr  out  XLEN  data memory address
- mem_wdata  out  XLEN  store data
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- EX_MEM_RegWrite  out  1  to forwarding unit
- EX_MEM_RegisterRD  out  5  to forwarding unit
- ex_mem_fwd_data  out  XLEN  EX/MEM ALU result for ForwardX=10
- MEM_WB_RegWrite  out  1  to forwarding unit and register file
- MEM_WB_RegisterRD  out  5  to forwarding unit and register file
- wb_data  out  XLEN  write-back value, also forward source for ForwardX=01

Behaviour:
- Reset (async, reset_n=0): all stage valid bits, control bits, rd fields and data registers clear to 0. All outputs are 0 while reset is asserted and until the first capture.
- EX/MEM state: em_valid, em_regwrite, em_memread, em_memwrite, em_memtoreg, em_rd, em_alu, em_sdata.
- MEM/WB state: wb_valid, wb_regwrite, wb_rd, wb_val.
- Per-instruction FSM in EX/MEM:
  - IDLE (em_valid=0).
  - OCCUPIED_ALU: valid, no memory op.
  - OCCUPIED_MEM: valid, memory op. Waits for mem_ready.
- hold = em_valid & (em_memread | em_memwrite) & ~mem_ready.
- ex_stall = hold, combinational.
- Each rising edge, priority order:
  1. flush: EX/MEM loads a bubble (em_valid=0). This applies even during hold; the killed access is abandoned and its strobes drop the next cycle. ex_* inputs are ignored that cycle.
  2. hold: EX/MEM retains its contents.
  3. Otherwise EX/MEM captures the ex_* inputs. em_valid = ex_valid.
- MEM/WB loads every edge:
  - If EX/MEM is valid, not held and not being flushed: wb_valid=1, wb_regwrite=em_regwrite, wb_rd=em_rd.
  - wb_val = mem_rdata if em_memtoreg, else em_alu.
  - Otherwise MEM/WB loads a bubble (wb_valid=0, wb_regwrite=0).
  - flush never kills MEM/WB.
- Output qualification:
  - EX_MEM_RegWrite = em_valid & em_regwrite & (em_rd != 0).
  - MEM_WB_RegWrite = wb_valid & wb_regwrite & (wb_rd != 0).
  - Writes to x0 are never visible to forwarding or the register file.
- mem_read = em_valid & em_memread.
- mem_write = em_valid & em_memwrite.
- mem_addr = em_alu; mem_wdata = em_sdata.
- Strobes stay high through a hold. A store completes on the edge where mem_ready=1.
- ex_mem_fwd_data = em_alu. A load in EX/MEM has EX_MEM_RegWrite=1, but the hazard unit must have stalled its consumer. This block does not check that.
- wb_data = wb_val.
- Latency: an instruction reaches MEM/WB 2 edges after EX capture, plus one edge per hold cycle.
- Simultaneous events:
  - flush with ex_valid=1: the new instruction is dropped.
  - reset mid-hold: the access is abandoned immediately (strobes 0 asynchronously).
- mem_ready while the stage is IDLE or OCCUPIED_ALU is ignored.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count (64 bits).
  - Counter increments on each edge where MEM/WB loads a valid instruction.
  - Cleared by reset; wraps from all-ones to 0.
  - Flushed and held instructions never count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset released, ex_valid=0 for 3 cycles -> all outputs 0, ex_stall=0.
- ALU op with rd=5, result 0x1234, mem_ready=1:
  - edge 1: EX_MEM_RegWrite=1, EX_MEM_RegisterRD=5, ex_mem_fwd_data=0x1234.
  - edge 2: MEM_WB_RegWrite=1, MEM_WB_RegisterRD=5, wb_data=0x1234.
- Load rd=7, addr 0x40, mem_ready=0 for 2 cycles then 1 with mem_rdata=0xDEADBEEF:
  - ex_stall=1 for exactly 2 cycles; mem_read high and mem_addr=0x40 throughout.
  - MEM/WB shows bubbles during the hold, then wb_data=0xDEADBEEF, rd=7.
- Store with flush asserted on its second hold cycle -> mem_write drops after that edge, ex_stall=0, no MEM/WB write. With RETIRE_COUNT_EN, retire_count is unchanged.
- ALU op writing rd=0 -> EX_MEM_RegWrite=0 and MEM_WB_RegWrite=0 throughout its passage.
- reset_n pulsed low mid-stream with valid instructions in both stages -> all outputs 0 immediately, without waiting for a clock edge.
